rand_history_viewer: RTL

//  Downstream consumer of the 8-bit LFSR random-byte generator. Captures each

---
 rtl/rand_history_viewer_if.sv | 27 ++
 rtl/rand_history_viewer.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/rand_history_viewer_if.sv
// Handshake and display bundle between the LFSR byte source/board I/O and rand_history_viewer.
// The master side drives the byte strobe, freeze switch and key; the slave side drives the status and 7-seg outputs.
interface rand_history_viewer_if;
    logic       in_valid;
    logic [7:0] in_data;
    logic       freeze;
    logic       key_n;
    logic [4:0] count;
    logic [3:0] view_off;
    logic       dup;
    logic [6:0] HEX0;
    logic [6:0] HEX1;
    logic [6:0] HEX2;
    logic [6:0] HEX3;
    logic [6:0] HEX4;
    logic [6:0] HEX5;

    modport master (
        output in_valid, in_data, freeze, key_n,
        input  count, view_off, dup, HEX0, HEX1, HEX2, HEX3, HEX4, HEX5
    );

    modport slave (
        input  in_valid, in_data, freeze, key_n,
        output count, view_off, dup, HEX0, HEX1, HEX2, HEX3, HEX4, HEX5
    );
endinterface

// File: rtl/rand_history_viewer.sv
// Circular history of generated random bytes with live/browse 7-seg display and a debounced browse key.
// Optional feature: define RHV_DUP_FLAG_EN to flag a capture that repeats the previously captured byte.
module rand_history_viewer #(
    parameter int DEPTH   = 8,
    parameter int DEB_CYC = 500000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    rand_history_viewer_if.slave bus
);
    localparam int              AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int              CW       = $clog2(DEB_CYC + 1);
    localparam logic [4:0]      DEPTH_C  = 5'(DEPTH);
    localparam logic [CW-1:0]   DEB_LAST = CW'(DEB_CYC - 1);
    localparam logic [6:0]      SEG_DASH  = 7'd63;
    localparam logic [6:0]      SEG_BLANK = 7'd127;

    typedef enum logic {LIVE = 1'b0, BROWSE = 1'b1} mode_t;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'd64;   4'h1: s = 7'd121;  4'h2: s = 7'd36;   4'h3: s = 7'd48;
            4'h4: s = 7'd25;   4'h5: s = 7'd18;   4'h6: s = 7'd2;    4'h7: s = 7'd120;
            4'h8: s = 7'd0;    4'h9: s = 7'd16;   4'hA: s = 7'd8;    4'hB: s = 7'd3;
            4'hC: s = 7'd70;   4'hD: s = 7'd33;   4'hE: s = 7'd6;    default: s = 7'd14;
        endcase
        return s;
    endfunction

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] sel;
    logic [7:0]    cur;
    logic [4:0]    count;
    logic [3:0]    view_off;
    mode_t         mode;
    logic          key_p0, key_p1, key_stable, press;
    logic [CW-1:0] deb_cnt;
    logic          capture;
    logic          dup;
    logic [6:0]    hex0, hex1, hex2, hex3, hex4, hex5;

    // Capture is gated by the raw switch so a byte arriving on the freeze edge is dropped.
    assign capture = bus.in_valid & ~bus.freeze;
    assign sel     = wr_ptr - AW'(1) - view_off[AW-1:0];
    assign cur     = mem[sel];

    always_ff @(posedge clk) begin
        if (capture) mem[wr_ptr] <= bus.in_data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            count  <= '0;
        end else if (capture) begin
            wr_ptr <= wr_ptr + AW'(1);
            if (count != DEPTH_C) count <= count + 5'd1;
        end
    end

    // Key synchroniser and debouncer; press fires once on an accepted 1->0 of the stable level.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            key_p0     <= 1'b1;
            key_p1     <= 1'b1;
            key_stable <= 1'b1;
            deb_cnt    <= '0;
            press      <= 1'b0;
        end else begin
            key_p0 <= bus.key_n;
            key_p1 <= key_p0;
            press  <= 1'b0;
            if (key_p1 == key_stable) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DEB_LAST) begin
                deb_cnt    <= '0;
                key_stable <= key_p1;
                press      <= key_stable & ~key_p1;
            end else begin
                deb_cnt <= deb_cnt + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode     <= LIVE;
            view_off <= '0;
        end else begin
            case (mode)
                LIVE: begin
                    view_off <= '0;
                    if (bus.freeze) mode <= BROWSE;
                end
                default: begin
                    if (!bus.freeze) begin
                        mode     <= LIVE;
                        view_off <= '0;
                    end else if (press && count != 5'd0) begin
                        view_off <= ({1'b0, view_off} == count - 5'd1) ? 4'd0 : view_off + 4'd1;
                    end
                end
            endcase
        end
    end

    // Display registers: one cycle behind the history/mode state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hex0 <= SEG_DASH;
            hex1 <= SEG_DASH;
            hex2 <= SEG_BLANK;
            hex3 <= SEG_BLANK;
            hex4 <= SEG_BLANK;
            hex5 <= SEG_BLANK;
        end else begin
            if (count == 5'd0) begin
                hex1 <= SEG_DASH;
                hex0 <= SEG_DASH;
            end else begin
                hex1 <= hex7(cur[7:4]);
                hex0 <= hex7(cur[3:0]);
            end
            hex2 <= (mode == BROWSE) ? hex7(view_off) : SEG_BLANK;
            hex3 <= SEG_BLANK;
            hex4 <= hex7(count[3:0]);
            hex5 <= count[4] ? 7'd121 : SEG_BLANK;
        end
    end

`ifdef RHV_DUP_FLAG_EN
    logic [7:0] last_p0;

    always_ff @(posedge clk) begin
        if (capture) last_p0 <= bus.in_data;
    end

    // count==0 means no previous byte exists, so the first capture after reset never flags.
    always_ff @(posedge clk) begin
        if (!rst_n) dup <= 1'b0;
        else        dup <= capture && (count != 5'd0) && (bus.in_data == last_p0);
    end
`else
    assign dup = 1'b0;
`endif

    assign bus.count    = count;
    assign bus.view_off = view_off;
    assign bus.dup      = dup;
    assign bus.HEX0     = hex0;
    assign bus.HEX1     = hex1;
    assign bus.HEX2     = hex2;
    assign bus.HEX3     = hex3;
    assign bus.HEX4     = hex4;
    assign bus.HEX5     = hex5;
endmodule
